// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access-size encodings,
// FSM state codes and the little-endian lane extract/merge helpers.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Pull the addressed byte/half down to bit 0 and extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lo,
                                                 input logic        sgn);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (size)
            SZ_BYTE: return {{24{sgn & sh[7]}},  sh[7:0]};
            SZ_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // Replace the addressed byte/half of word with the low bits of wdata.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo);
        logic [31:0] mask;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: return wdata;
        endcase
        return (word & ~(mask << {lo, 3'b000})) | ((wdata & mask) << {lo, 3'b000});
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane alignment: extract/extend for load return and
// read-modify-write merge for sub-word stores, selected by size and lane.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  lo_i,
    input  logic        sgn_i,
    output logic [31:0] ext_o,
    output logic [31:0] merged_o
);

    // Both views are derived from the same fetched word.
    always_comb begin
        ext_o    = lane_extract(word_i, size_i, lo_i, sgn_i);
        merged_o = lane_merge(word_i, wdata_i, size_i, lo_i);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory. Sub-word stores use
// read-modify-write; loads return aligned and extended data.
// Optional: MAU_MISALIGN_TRAP_EN makes misaligned half/word accesses errors;
// otherwise the low address bits below the access size are ignored.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_write,
    output logic        dm_read,
    input  logic [31:0] dm_rdata
);

    logic [1:0]  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic        dm_write_q, dm_write_d;
    logic        dm_read_q, dm_read_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lo_q, lo_d;
    logic        sgn_q, sgn_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;

    logic          accept, req_err, mis_err;
    logic [AW-1:0] idx;
    logic [1:0]    lo_a;
    logic [31:0]   rd_ext, wr_merged;

    assign accept = req_valid && req_ready_q;
    assign idx    = req_addr[AW+1:2];

    // Lane within the word; sub-size bits are dropped so accesses stay aligned.
    always_comb begin
        case (req_size)
            SZ_BYTE: lo_a = req_addr[1:0];
            SZ_HALF: lo_a = {req_addr[1], 1'b0};
            default: lo_a = 2'b00;
        endcase
    end

    // Request rejection: out of range, reserved size, optionally misaligned.
    always_comb begin
`ifdef MAU_MISALIGN_TRAP_EN
        mis_err = ((req_size == SZ_HALF) && req_addr[0]) ||
                  ((req_size == SZ_WORD) && (|req_addr[1:0]));
`else
        mis_err = 1'b0;
`endif
        req_err = (|req_addr[31:AW+2]) ||
                  ({{(32-AW){1'b0}}, idx} >= 32'(DEPTH)) ||
                  (req_size == 2'b11) || mis_err;
    end

    mau_lane_align u_align (
        .word_i   (dm_rdata),
        .wdata_i  (wdata_q),
        .size_i   (size_q),
        .lo_i     (lo_q),
        .sgn_i    (sgn_q),
        .ext_o    (rd_ext),
        .merged_o (wr_merged)
    );

    // FSM next state and registered-output next values.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        dm_write_d   = dm_write_q;
        dm_read_d    = dm_read_q;
        size_d       = size_q;
        lo_d         = lo_q;
        sgn_d        = sgn_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                req_ready_d = 1'b0;
                size_d      = req_size;
                lo_d        = lo_a;
                sgn_d       = req_signed;
                we_d        = req_we;
                wdata_d     = req_wdata;
                if (req_err) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0;
                end else if (req_we && (req_size == SZ_WORD)) begin
                    state_d    = ST_WR;
                    dm_addr_d  = {{(32-AW){1'b0}}, idx};
                    dm_wdata_d = req_wdata;
                    dm_write_d = 1'b1;
                end else begin
                    state_d   = ST_RD;
                    dm_addr_d = {{(32-AW){1'b0}}, idx};
                    dm_read_d = 1'b1;
                end
            end
            ST_RD: begin
                dm_read_d = 1'b0;
                if (we_q) begin
                    state_d    = ST_WR;
                    dm_wdata_d = wr_merged;
                    dm_write_d = 1'b1;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = rd_ext;
                    resp_err_d   = 1'b0;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                dm_write_d   = 1'b0;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            dm_addr_q    <= 32'h0;
            dm_wdata_q   <= 32'h0;
            dm_write_q   <= 1'b0;
            dm_read_q    <= 1'b0;
            size_q       <= SZ_BYTE;
            lo_q         <= 2'b00;
            sgn_q        <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            dm_write_q   <= dm_write_d;
            dm_read_q    <= dm_read_d;
            size_q       <= size_d;
            lo_q         <= lo_d;
            sgn_q        <= sgn_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign dm_addr    = dm_addr_q;
    assign dm_wdata   = dm_wdata_q;
    assign dm_write   = dm_write_q;
    assign dm_read    = dm_read_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store initiator between the datapath and the word-addressed data memory. The memory port is word-only: 64 x 32, combinational read, level-sensitive write. This block accepts byte/half/word load and store requests from the execute stage and issues the word-level read/write strobes. Sub-word stores use read-modify-write. Loads are returned aligned and sign/zero-extended.

Parameters:
DEPTH, 64, number of 32-bit words in data memory
AW, 6, word-index width (clog2(DEPTH))

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  in  1  sign-extend load result
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result (0 for stores)
resp_err  out  1  request rejected (misaligned/out of range/reserved size)
dm_addr  out  32  word index to memory, upper bits zero
dm_wdata  out  32  write data to memory
dm_write  out  1  memory write strobe
dm_read  out  1  memory read strobe
dm_rdata  in  32  memory read data (combinational)

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=1 once released; resp_valid=0, resp_rdata=0, resp_err=0, dm_write=0, dm_read=0, dm_addr=0, dm_wdata=0.
- All outputs are registered. Handshake: accept on req_valid && req_ready at a clk edge; the request is latched and the inputs are ignored afterwards.
- FSM states: IDLE, RD, WR, RESP.
- IDLE -> RD: accepted load, or accepted byte/half store. dm_read=1, dm_addr=req_addr[AW+1:2].
- IDLE -> WR: accepted word store. dm_write=1, dm_wdata=req_wdata.
- IDLE -> RESP: error request. No dm strobe is issued.
- RD: capture dm_rdata at end of cycle.
  - Load: extract lane (byte lane = addr[1:0], half lane = addr[1]), little-endian; extend per req_signed; -> RESP.
  - Sub-word store: merge req_wdata low byte/half into the captured word at the lane; dm_read=0; -> WR.
- WR: dm_write=1 for exactly one cycle, same dm_addr; -> RESP.
- RESP: resp_valid=1 for one cycle with resp_rdata/resp_err; -> IDLE. req_ready returns high the following cycle.
- Latency accept->resp_valid:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Errors: word index >= DEPTH, or req_addr[31:AW+2] nonzero; size 11; resp_err=1, resp_rdata=0, no memory side effect.
- dm_read and dm_write are never high in the same cycle.
- dm_addr/dm_wdata are held stable for the full strobe cycle.
- Reset mid-operation aborts immediately. A write strobe is dropped by deasserting; a partially merged store never completes. No response is generated.
- Address word DEPTH-1 is valid; DEPTH wraps nowhere and is an error.

Optional Feature:
MAU_MISALIGN_TRAP_EN
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, is an error (resp_err=1, no access).
- Undefined: low address bits below access size are ignored (forced to 0), and the access proceeds aligned.

Decomposition:
- Package mau_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum;
  - lane extract and lane merge functions.
- One sub-module, mau_lane_align: combinational extract/extend and merge by size and addr[1:0]. It is reused for both load return and store merge.

Test Plan:
- Reset, then load word addr 0x08 with mem[2]=0xDEADBEEF -> dm_read 1 cycle at dm_addr=2; resp_valid 2 cycles after accept; resp_rdata=0xDEADBEEF.
- Signed byte load addr 0x0B, mem[2]=0x80FF1234 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Byte store 0xAA to addr 0x05, mem[1]=0x11223344 -> dm_read then dm_write; dm_wdata=0x1122AA44; resp at 3 cycles.
- Word load addr 0x100 (index 64) -> resp_err=1 after 1 cycle; dm_read/dm_write never asserted.
- Half load addr 0x03: with MAU_MISALIGN_TRAP_EN -> resp_err=1; without it -> returns bits [31:16] of word 0.
- Assert rst_n low during WR of a half store -> dm_write drops immediately; no resp_valid; req_ready=1 after release.
